// File: rtl/seq_divider12_pkg.sv
// Shared definitions for the sequential restoring divider: widths, count size and FSM encoding.
package seq_divider12_pkg;

  localparam int N_W_DEF = 12;
  localparam int D_W_DEF = 6;
  localparam int CNT_W   = $clog2(N_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/rbs7.sv
// 7-bit ripple-borrow subtractor, r = a - b, built from a chain of full-subtractor cells.
module rbs7 (
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic [6:0] r,
  output logic       borrow_out
);

  logic [7:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < 7; i++) begin : g_fs
    assign r[i]     = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign borrow_out = bw[7];

endmodule

// File: rtl/seq_divider12.sv
// Sequential restoring divider: 12-bit dividend / 6-bit divisor, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one shift/subtract iteration per clock, N_W iterations
// FIN   | done pulse; results valid from this cycle on
module seq_divider12
  import seq_divider12_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder
);

  state_e           state_q, state_d;
  logic [N_W-1:0]   q_q, q_d;
  logic [D_W-1:0]   d_q, d_d;
  logic [D_W:0]     p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0]   quo_q, quo_d;
  logic [D_W-1:0]   rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [D_W+1:0]   sh;
  logic [D_W:0]     t;
  logic             borrow;
  logic             ge;
  logic [D_W:0]     p_nxt;
  logic [N_W-1:0]   q_nxt;

  assign sh = {p_q, q_q[N_W-1]};

  rbs7 u_sub (
    .a          (sh[D_W:0]),
    .b          ({1'b0, d_q}),
    .r          (t),
    .borrow_out (borrow)
  );

  // A set bit above the subtractor width means the shifted value already exceeds d.
  assign ge    = sh[D_W+1] | ~borrow;
  assign p_nxt = ge ? t : sh[D_W:0];
  assign q_nxt = {q_q[N_W-2:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          p_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = FIN;
            quo_d   = '1;
            rem_d   = dividend[D_W-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d   = p_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_W - 1)) begin
          state_d = FIN;
          quo_d   = q_nxt;
          rem_d   = p_nxt[D_W-1:0];
          dbz_d   = 1'b0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;

endmodule
